csk_serial_subtractor: RTL and testbench
========================================

// Module: csk_serial_subtractor
// PURPOSE
//  Multi-cycle A - B - Bin subtractor built on the 4-bit carry-skip block, operating in the
//  borrow domain. Computes A + ~B + ~Bin, one 4-bit block per clock, with an internal carry
//  register between blocks. Skip bypass applies per block.
//  Valid/ready on both sides; sits beside the combinational cska adders in the datapath.
// PARAMETERS
//  WIDTH   16   operand width; multiple of 4, >= 8
//  NBLK    WIDTH/4 (localparam)   number of 4-bit blocks, one per RUN cycle
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      accepts operands; high only in IDLE
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow in
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      downstream accepts result
//  diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//  bout       out  1      borrow out; 1 when unsigned a < b + bin
//  ovf        out  1      signed overflow
//  skip_cnt   out  16     skip statistics; present only with CSK_SKIP_STATS_EN
// BEHAVIOUR
//  Reset (async): state=IDLE; in_ready=1; out_valid=0; diff=0; bout=0; ovf=0; carry reg=0; blk idx=0.
//  FSM: IDLE -> RUN on in_valid&in_ready.
//   - On acceptance, latch a, ~b, and carry = ~bin.
//  RUN: each edge processes block k, bits [4k+3:4k]; writes diff slice; k++.
//   - Ripple inside the block. Per-bit propagate p = a ^ ~b.
//   - skip = &p[blk]; carry_out = skip ? carry_in : ripple carry.
//   - After block NBLK-1: RUN -> DONE.
//  DONE: out_valid=1, outputs stable.
//   - On out_valid&out_ready: -> IDLE; out_valid drops next edge; in_ready=1 from that cycle.
//  Latency: out_valid asserts exactly NBLK cycles after the accept edge (16-bit: 4).
//   - Throughput: one op per NBLK+2 cycles minimum; no overlap.
//  Result bits:
//   - bout = ~final carry.
//   - ovf = (a[W-1]!=b[W-1]) & (diff[W-1]!=a[W-1]).
//  diff, bout and ovf are valid only while out_valid; diff slices update during RUN.
//  in_valid during RUN/DONE is ignored (in_ready=0); operand inputs are not sampled after accept.
//  out_ready low in DONE: all outputs hold indefinitely.
//  out_ready high before DONE: no effect.
//  Reset during RUN/DONE aborts the operation; no out_valid is produced for it.
//  Wrap: modulo 2^WIDTH; a=0, b=max, bin=1 -> diff=0, bout=1.
// CONFIGURATION
//  CSK_SKIP_STATS_EN defined:
//   - skip_cnt port exists; 16-bit counter, +1 per RUN block with skip=1.
//   - Saturates at 16'hFFFF; cleared by rst only.
//  Not defined: no skip_cnt port and no counter logic; all other behaviour identical.
// TESTING (WIDTH=16)
//  a=1234h, b=0234h, bin=0 -> diff=1000h, bout=0, ovf=0; out_valid exactly 4 cycles after accept.
//  a=0000h, b=0001h, bin=0 -> diff=FFFFh, bout=1, ovf=0.
//  a=8000h, b=0001h, bin=0 -> diff=7FFFh, bout=0, ovf=1.
//  a=b=5A5Ah, bin=1 -> diff=FFFFh, bout=1; all 4 blocks skip; skip_cnt +4 (with CSK_SKIP_STATS_EN).
//  DONE with out_ready=0 for 3 cycles plus new in_valid -> diff/bout held, in_ready=0;
//   - second op accepted only after out_ready handshake.
//  rst pulsed after 2 RUN blocks -> out_valid=0, in_ready=1, diff=0 immediately;
//   - next op a=0010h, b=0001h -> diff=000Fh.

Source files
------------

// File: rtl/csk_serial_subtractor.sv
// csk_serial_subtractor: multi-cycle a - b - bin, one 4-bit carry-skip block per clock.
// Optional skip statistics counter and skip_cnt port with CSK_SKIP_STATS_EN.
module csk_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
`ifdef CSK_SKIP_STATS_EN
    output logic [15:0]      skip_cnt,
`endif
    output logic             ovf
);
    localparam int NBLK = WIDTH / 4;
    localparam int KW = (NBLK > 1) ? $clog2(NBLK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, nb_q, nb_d, diff_q, diff_d;
    logic             carry_q, carry_d, bout_q, bout_d, ovf_q, ovf_d;
    logic [KW-1:0]    k_q, k_d;
    logic [3:0]       a4, nb4, p4;
    logic [4:0]       sum5;
    logic             skip, cout, last;

    // Borrow domain: a - b - bin == a + ~b + ~bin, so a final carry of 0 means a borrow.
    assign a4   = a_q[{k_q, 2'b00} +: 4];
    assign nb4  = nb_q[{k_q, 2'b00} +: 4];
    assign p4   = a4 ^ nb4;
    assign sum5 = {1'b0, a4} + {1'b0, nb4} + {4'b0, carry_q};
    assign skip = &p4;
    assign cout = skip ? carry_q : sum5[4];
    assign last = (k_q == KW'(NBLK - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        nb_d    = nb_q;
        diff_d  = diff_q;
        carry_d = carry_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        k_d     = k_q;
        if (state_q == IDLE && in_valid) begin
            state_d = RUN;
            a_d     = a;
            nb_d    = ~b;
            carry_d = ~bin;
            k_d     = '0;
        end else if (state_q == RUN) begin
            diff_d[{k_q, 2'b00} +: 4] = sum5[3:0];
            carry_d = cout;
            k_d     = k_q + 1'b1;
            if (last) begin
                state_d = DONE;
                bout_d  = ~cout;
                ovf_d   = (a_q[WIDTH-1] == nb_q[WIDTH-1]) & (sum5[3] != a_q[WIDTH-1]);
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            nb_q    <= '0;
            diff_q  <= '0;
            carry_q <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            diff_q  <= diff_d;
            carry_q <= carry_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
        end
    end

`ifdef CSK_SKIP_STATS_EN
    logic [15:0] skip_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            skip_cnt_q <= '0;
        else if (state_q == RUN && skip && skip_cnt_q != 16'hFFFF)
            skip_cnt_q <= skip_cnt_q + 16'd1;
    end
    assign skip_cnt = skip_cnt_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_csk_serial_subtractor.sv
// tb_csk_serial_subtractor: directed checks of the serial carry-skip subtractor (WIDTH=16).
module tb_csk_serial_subtractor;
    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0, bin = 0;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, bout, ovf;
    logic [15:0] diff;
`ifdef CSK_SKIP_STATS_EN
    logic [15:0] skip_cnt;
`endif
    int tests = 0, fails = 0;

    csk_serial_subtractor #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout),
`ifdef CSK_SKIP_STATS_EN
        .skip_cnt(skip_cnt),
`endif
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                          output int lat, output logic [15:0] d, output logic bo, output logic ov);
        int n;
        lat = -1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        a = ta; b = tb_v; bin = tbin; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0; a = 16'hDEAD; b = 16'hBEEF; bin = ~tbin;
        for (int i = 1; i <= 20; i++) begin
            if (out_valid) break;
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        d = diff; bo = bout; ov = ovf;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic test_reset;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 16'h0 || bout !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset: in_ready=%b out_valid=%b diff=%h bout=%b ovf=%b, want 1 0 0000 0 0",
                     in_ready, out_valid, diff, bout, ovf);
        end
    endtask

    task automatic test_basic;
        logic [15:0] va [4] = '{16'h1234, 16'h0000, 16'h8000, 16'h0000};
        logic [15:0] vb [4] = '{16'h0234, 16'h0001, 16'h0001, 16'hFFFF};
        logic        vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] ed [4] = '{16'h1000, 16'hFFFF, 16'h7FFF, 16'h0000};
        logic        eb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        eo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int lat;
        logic [15:0] d;
        logic bo, ov;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vc[i], lat, d, bo, ov);
            tests++;
            if (lat !== 4) begin
                fails++;
                $display("FAIL basic%0d latency: got %0d, want 4", i, lat);
            end
            tests++;
            if (d !== ed[i] || bo !== eb[i] || ov !== eo[i]) begin
                fails++;
                $display("FAIL basic%0d result: diff=%h bout=%b ovf=%b, want %h %b %b",
                         i, d, bo, ov, ed[i], eb[i], eo[i]);
            end
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL basic%0d handshake: out_valid=%b in_ready=%b, want 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_skip;
        int lat;
        logic [15:0] d;
        logic bo, ov;
`ifdef CSK_SKIP_STATS_EN
        logic [15:0] before = skip_cnt;
`endif
        run_op(16'h5A5A, 16'h5A5A, 1'b1, lat, d, bo, ov);
        tests++;
        if (d !== 16'hFFFF || bo !== 1'b1 || ov !== 1'b0 || lat !== 4) begin
            fails++;
            $display("FAIL skip result: diff=%h bout=%b ovf=%b lat=%0d, want FFFF 1 0 4", d, bo, ov, lat);
        end
`ifdef CSK_SKIP_STATS_EN
        tests++;
        if (skip_cnt !== before + 16'd4) begin
            fails++;
            $display("FAIL skip_cnt: got %h, want %h", skip_cnt, before + 16'd4);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int n;
        a = 16'h1234; b = 16'h0234; bin = 0; in_valid = 1;
        @(posedge clk); #1;
        a = 16'h0003; b = 16'h0005;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if (n !== 4) begin
            fails++;
            $display("FAIL bp latency: got %0d, want 4", n);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 16'h1000 || bout !== 1'b0) begin
                fails++;
                $display("FAIL bp hold%0d: out_valid=%b in_ready=%b diff=%h bout=%b, want 1 0 1000 0",
                         i, out_valid, in_ready, diff, bout);
            end
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if (n !== 4 || diff !== 16'hFFFE || bout !== 1'b1 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL bp second: lat=%0d diff=%h bout=%b ovf=%b, want 4 FFFE 1 0", n, diff, bout, ovf);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic test_abort;
        int lat;
        logic [15:0] d;
        logic bo, ov;
        a = 16'hFFFF; b = 16'h0001; bin = 0; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (diff[7:0] !== 8'hFE || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort partial: diff[7:0]=%h out_valid=%b, want FE 0", diff[7:0], out_valid);
        end
        rst = 1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 16'h0) begin
            fails++;
            $display("FAIL abort reset: out_valid=%b in_ready=%b diff=%h, want 0 1 0000", out_valid, in_ready, diff);
        end
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        run_op(16'h0010, 16'h0001, 1'b0, lat, d, bo, ov);
        tests++;
        if (d !== 16'h000F || bo !== 1'b0 || ov !== 1'b0 || lat !== 4) begin
            fails++;
            $display("FAIL abort next: diff=%h bout=%b ovf=%b lat=%0d, want 000F 0 0 4", d, bo, ov, lat);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        rst = 0;
        @(posedge clk); #1;
        test_basic;
        test_skip;
        test_back_to_back;
        test_abort;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
